tone_frame_sequencer: RTL and testbench

- Controller in front of the tone-detector datapath (detector logic, magnitude LUT, tone LUT).
- Frames the incoming sample stream into blocks of FRAME_LEN samples and gates the detector's enable for each frame.
- Collects the tone code on done and enforces debounce: a digit must persist HOLD_FRAMES frames, and GAP_FRAMES silent frames are required between digits.
- Queues validated tone codes in a small FIFO read by the host interface.

---
 rtl/tone_frame_sequencer_pkg.sv | 32 +++
 rtl/tone_digit_fifo.sv | 58 +++++
 rtl/tone_frame_sequencer.sv | 147 ++++++++++++++
 tb/tb_tone_frame_sequencer.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tone_frame_sequencer_pkg.sv
// Shared constants and types for the tone frame sequencer and its digit FIFO.
package tone_frame_sequencer_pkg;

   localparam logic [15:0] TONE_NONE = 16'd0;
   localparam logic [15:0] TONE_1    = 16'd1;
   localparam logic [15:0] TONE_2    = 16'd2;
   localparam logic [15:0] TONE_3    = 16'd3;
   localparam logic [15:0] TONE_4    = 16'd4;
   localparam logic [15:0] TONE_5    = 16'd5;
   localparam logic [15:0] TONE_6    = 16'd6;
   localparam logic [15:0] TONE_7    = 16'd7;
   localparam logic [15:0] TONE_8    = 16'd8;
   localparam logic [15:0] TONE_9    = 16'd9;
   localparam logic [15:0] TONE_0    = 16'd10;
   localparam logic [15:0] TONE_STAR = 16'd11;
   localparam logic [15:0] TONE_HASH = 16'd12;
   localparam logic [15:0] TONE_A    = 16'd13;
   localparam logic [15:0] TONE_B    = 16'd14;
   localparam logic [15:0] TONE_C    = 16'd15;
   localparam logic [15:0] TONE_D    = 16'd16;

   typedef enum logic [1:0] {
      StFeed,
      StWaitDone,
      StEval
   } seq_state_t;

   localparam int unsigned STATUS_TIMEOUT     = 0;
   localparam int unsigned STATUS_FIFO_OVF    = 1;
   localparam int unsigned STATUS_SAMPLE_DROP = 2;

endpackage

// File: rtl/tone_digit_fifo.sv
// Synchronous FIFO for accepted tone codes; head is shown from registered storage.
module tone_digit_fifo #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned WIDTH = 16
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         head,
   output logic                     valid,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overflow
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_COUNT = DEPTH[AW:0];

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [AW:0]      count_q;
   logic             full, empty, do_push, do_pop;

   assign empty    = (count_q == '0);
   assign full     = (count_q == FULL_COUNT);
   assign do_pop   = pop && !empty;
   // A pop frees the slot this cycle, so a push at full still lands.
   assign do_push  = push && (!full || do_pop);
   assign overflow = push && full && !pop;

   assign head  = empty ? '0 : mem_q[rd_ptr_q];
   assign valid = !empty;
   assign count = count_q;

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= push_data;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         unique case ({do_push, do_pop})
            2'b10:   count_q <= count_q + (AW + 1)'(1);
            2'b01:   count_q <= count_q - (AW + 1)'(1);
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/tone_frame_sequencer.sv
// Frames samples for the tone detector, debounces its per-frame results and
// queues accepted digits for the host.
module tone_frame_sequencer
   import tone_frame_sequencer_pkg::*;
#(
   parameter int unsigned FRAME_LEN   = 205,
   parameter int unsigned TIMEOUT     = 1024,
   parameter int unsigned HOLD_FRAMES = 2,
   parameter int unsigned GAP_FRAMES  = 1,
   parameter int unsigned FIFO_DEPTH  = 8
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic                          sample_valid,
   input  logic [15:0]                   sample_in,
   output logic                          det_enable,
   output logic [15:0]                   det_data,
   input  logic                          det_done,
   input  logic [15:0]                   det_tone,
   output logic                          digit_valid,
   output logic [15:0]                   digit,
   input  logic                          digit_ready,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic [2:0]                    status,
   input  logic                          clr_status
);

   localparam int unsigned SCW = $clog2(FRAME_LEN);
   localparam int unsigned TCW = $clog2(TIMEOUT);
   localparam int unsigned RW  = $clog2(HOLD_FRAMES + 1);
   localparam int unsigned GW  = $clog2(GAP_FRAMES + 1);

   seq_state_t      state_q;
   logic [SCW-1:0]  sample_cnt_q;
   logic [TCW-1:0]  timeout_cnt_q;
   logic [15:0]     frame_tone_q, cand_q, cand_d;
   logic [RW-1:0]   run_q, run_d;
   logic [GW-1:0]   sil_q, sil_d;
   logic            armed_q, armed_d;
   logic [2:0]      status_q, status_set;
   logic            push, fifo_ovf, timed_out;

   assign timed_out = (state_q == StWaitDone) && !det_done &&
                      (timeout_cnt_q == TCW'(TIMEOUT - 1));
   assign status    = status_q;

   always_comb begin
      status_set                     = '0;
      status_set[STATUS_TIMEOUT]     = timed_out;
      status_set[STATUS_FIFO_OVF]    = fifo_ovf;
      status_set[STATUS_SAMPLE_DROP] = sample_valid && (state_q != StFeed);
   end

   // Debounce: next candidate/run/silence/armed for the latched frame result.
   always_comb begin
      cand_d  = cand_q;
      run_d   = run_q;
      sil_d   = sil_q;
      armed_d = armed_q;
      if (frame_tone_q == TONE_NONE) begin
         cand_d = TONE_NONE;
         run_d  = '0;
         if (sil_q != GW'(GAP_FRAMES)) sil_d = sil_q + GW'(1);
         if (sil_d == GW'(GAP_FRAMES)) armed_d = 1'b1;
      end else begin
         sil_d = '0;
         if (frame_tone_q == cand_q) begin
            if (run_q != RW'(HOLD_FRAMES)) run_d = run_q + RW'(1);
         end else begin
            cand_d = frame_tone_q;
            run_d  = RW'(1);
         end
      end
      push = (state_q == StEval) && (run_d == RW'(HOLD_FRAMES)) && armed_q;
      if (push) armed_d = 1'b0;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= StFeed;
         sample_cnt_q  <= '0;
         timeout_cnt_q <= '0;
         frame_tone_q  <= TONE_NONE;
         cand_q        <= TONE_NONE;
         run_q         <= '0;
         sil_q         <= '0;
         armed_q       <= 1'b1;
         status_q      <= '0;
         det_enable    <= 1'b0;
         det_data      <= '0;
      end else begin
         status_q   <= (clr_status ? 3'b000 : status_q) | status_set;
         det_enable <= 1'b0;
         unique case (state_q)
            StFeed: begin
               if (sample_valid) begin
                  det_enable <= 1'b1;
                  det_data   <= sample_in;
                  if (sample_cnt_q == SCW'(FRAME_LEN - 1)) begin
                     sample_cnt_q <= '0;
                     state_q      <= StWaitDone;
                  end else begin
                     sample_cnt_q <= sample_cnt_q + SCW'(1);
                  end
               end
            end
            StWaitDone: begin
               if (det_done) begin
                  frame_tone_q  <= det_tone;
                  timeout_cnt_q <= '0;
                  state_q       <= StEval;
               end else if (timed_out) begin
                  frame_tone_q  <= TONE_NONE;
                  timeout_cnt_q <= '0;
                  state_q       <= StEval;
               end else begin
                  timeout_cnt_q <= timeout_cnt_q + TCW'(1);
               end
            end
            StEval: begin
               cand_q  <= cand_d;
               run_q   <= run_d;
               sil_q   <= sil_d;
               armed_q <= armed_d;
               state_q <= StFeed;
            end
            default: state_q <= StFeed;
         endcase
      end
   end

   tone_digit_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (16)
   ) u_fifo (
      .clk       (clk),
      .reset_n   (reset_n),
      .push      (push),
      .push_data (cand_d),
      .pop       (digit_ready),
      .head      (digit),
      .valid     (digit_valid),
      .count     (fifo_count),
      .overflow  (fifo_ovf)
   );

endmodule

// File: tb/tb_tone_frame_sequencer.sv
// Bench for tone_frame_sequencer: behavioural model compared every cycle plus
// hand-computed checkpoints for the directed scenarios.
module tb_tone_frame_sequencer;

   localparam int unsigned FRAME_LEN = 205;
   localparam int unsigned TIMEOUT   = 1024;
   localparam int unsigned HOLD      = 2;
   localparam int unsigned GAP       = 1;
   localparam int unsigned DEPTH     = 8;

   logic        clk = 1'b0, reset_n = 1'b0;
   logic        sample_valid = 1'b0, det_done = 1'b0, digit_ready = 1'b0, clr_status = 1'b0;
   logic [15:0] sample_in = '0, det_tone = '0;
   logic        det_enable, digit_valid;
   logic [15:0] det_data, digit;
   logic [3:0]  fifo_count;
   logic [2:0]  status;

   int checks = 0, errors = 0, en_cnt = 0;
   bit rand_pop = 1'b0, rand_noise = 1'b0;

   always #5 clk = ~clk;

   tone_frame_sequencer #(
      .FRAME_LEN   (FRAME_LEN),
      .TIMEOUT     (TIMEOUT),
      .HOLD_FRAMES (HOLD),
      .GAP_FRAMES  (GAP),
      .FIFO_DEPTH  (DEPTH)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .sample_valid (sample_valid),
      .sample_in    (sample_in),
      .det_enable   (det_enable),
      .det_data     (det_data),
      .det_done     (det_done),
      .det_tone     (det_tone),
      .digit_valid  (digit_valid),
      .digit        (digit),
      .digit_ready  (digit_ready),
      .fifo_count   (fifo_count),
      .status       (status),
      .clr_status   (clr_status)
   );

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endfunction

   // Model: phase 0 = feeding, 1 = waiting for result, 2 = judging the frame.
   int          m_phase = 0, m_cnt = 0, m_waited = 0, m_run = 0, m_sil = 0;
   logic [15:0] m_cand = '0, m_result = '0, m_data = '0, m_pv = '0;
   bit          m_en = 1'b0, m_armed = 1'b1, m_push = 1'b0;
   logic [2:0]  m_status = '0, m_set = '0;
   logic [15:0] m_q[$];

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_phase = 0; m_cnt = 0; m_waited = 0; m_run = 0; m_sil = 0;
         m_cand = '0; m_result = '0; m_data = '0; m_en = 1'b0; m_armed = 1'b1;
         m_status = '0;
         m_q.delete();
      end else begin
         m_set  = '0;
         m_push = 1'b0;
         m_en   = 1'b0;
         if (m_phase != 0 && sample_valid) m_set[2] = 1'b1;
         if (m_phase == 0) begin
            if (sample_valid) begin
               m_en   = 1'b1;
               m_data = sample_in;
               m_cnt  = m_cnt + 1;
               if (m_cnt == FRAME_LEN) begin
                  m_cnt   = 0;
                  m_phase = 1;
               end
            end
         end else if (m_phase == 1) begin
            if (det_done) begin
               m_result = det_tone; m_phase = 2; m_waited = 0;
            end else if (m_waited + 1 == TIMEOUT) begin
               m_set[0] = 1'b1; m_result = 0; m_phase = 2; m_waited = 0;
            end else begin
               m_waited = m_waited + 1;
            end
         end else begin
            if (m_result == 0) begin
               m_run  = 0;
               m_cand = 0;
               m_sil  = (m_sil + 1 > GAP) ? GAP : m_sil + 1;
               if (m_sil == GAP) m_armed = 1'b1;
            end else begin
               if (m_result == m_cand) begin
                  m_run = (m_run + 1 > HOLD) ? HOLD : m_run + 1;
               end else begin
                  m_cand = m_result;
                  m_run  = 1;
               end
               m_sil = 0;
               if (m_run == HOLD && m_armed) begin
                  m_push  = 1'b1;
                  m_pv    = m_cand;
                  m_armed = 1'b0;
               end
            end
            m_phase = 0;
         end
         if (digit_ready && m_q.size() > 0) void'(m_q.pop_front());
         if (m_push) begin
            if (m_q.size() < DEPTH) m_q.push_back(m_pv);
            else m_set[1] = 1'b1;
         end
         m_status = (clr_status ? 3'b000 : m_status) | m_set;
      end
   end

   always @(negedge clk) begin
      chk("det_enable", det_enable, m_en);
      chk("det_data", det_data, m_data);
      chk("digit_valid", digit_valid, m_q.size() > 0);
      chk("digit", digit, (m_q.size() > 0) ? m_q[0] : 16'd0);
      chk("fifo_count", fifo_count, m_q.size());
      chk("status", status, m_status);
      if (det_enable) en_cnt++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      tick();
      tick();
      reset_n = 1'b1;
      tick();
   endtask

   task automatic feed_frame(input int n, input int gap_pct);
      int sent = 0;
      while (sent < n) begin
         digit_ready = rand_pop && ($urandom_range(3) == 0);
         clr_status  = rand_noise && ($urandom_range(49) == 0);
         det_done    = rand_noise && ($urandom_range(29) == 0);
         det_tone    = 16'($urandom_range(16));
         if ($urandom_range(99) < gap_pct) begin
            sample_valid = 1'b0;
         end else begin
            sample_valid = 1'b1;
            sample_in    = 16'($urandom);
            sent++;
         end
         tick();
      end
      sample_valid = 1'b0; digit_ready = 1'b0; clr_status = 1'b0; det_done = 1'b0;
   endtask

   task automatic finish_frame(input logic [15:0] tone, input int delay, input bit pop_eval,
                               input bit stray);
      for (int i = 0; i < delay; i++) begin
         sample_valid = stray && ($urandom_range(7) == 0);
         sample_in    = 16'($urandom);
         tick();
      end
      sample_valid = 1'b0;
      det_done     = 1'b1;
      det_tone     = tone;
      tick();
      det_done    = 1'b0;
      det_tone    = 16'($urandom);
      digit_ready = pop_eval;
      tick();
      digit_ready = 1'b0;
   endtask

   task automatic frame(input logic [15:0] tone);
      feed_frame(FRAME_LEN, 0);
      finish_frame(tone, $urandom_range(0, 20), 1'b0, 1'b0);
   endtask

   initial begin
      tick();
      tick();
      reset_n = 1'b1;
      tick();
      chk("rst_det_enable", det_enable, 0);
      chk("rst_det_data", det_data, 0);
      chk("rst_digit_valid", digit_valid, 0);
      chk("rst_fifo_count", fifo_count, 0);
      chk("rst_status", status, 0);

      // One contiguous frame: 205 pulses, then silence while waiting.
      en_cnt = 0;
      feed_frame(FRAME_LEN, 0);
      repeat (6) tick();
      chk("frame_enable_count", en_cnt, 205);
      finish_frame(16'd5, 3, 1'b0, 1'b0);

      // 5,5,0,5,5 -> two 5s queued.
      do_reset();
      frame(16'd5); frame(16'd5); frame(16'd0); frame(16'd5); frame(16'd5);
      chk("debounce_count", fifo_count, 2);
      chk("debounce_digit", digit, 5);
      digit_ready = 1'b1;
      tick();
      tick();
      digit_ready = 1'b0;
      chk("drain_count", fifo_count, 0);

      // 5,5,9,9 -> only 5, the change without silence is not reported.
      do_reset();
      frame(16'd5); frame(16'd5); frame(16'd9); frame(16'd9);
      chk("change_count", fifo_count, 1);
      chk("change_digit", digit, 5);

      // Withheld result -> timeout flag, then cleared, then a full frame is accepted.
      do_reset();
      feed_frame(FRAME_LEN, 0);
      repeat (TIMEOUT + 3) tick();
      chk("timeout_status", status, 3'b001);
      clr_status = 1'b1;
      tick();
      clr_status = 1'b0;
      chk("clr_status", status, 3'b000);
      en_cnt = 0;
      feed_frame(FRAME_LEN, 0);
      tick();
      chk("post_timeout_enables", en_cnt, 205);
      finish_frame(16'd0, 2, 1'b0, 1'b0);

      // Sample arriving while waiting is dropped and flagged.
      do_reset();
      feed_frame(FRAME_LEN, 0);
      sample_valid = 1'b1;
      sample_in    = 16'h1234;
      tick();
      sample_valid = 1'b0;
      chk("drop_status", status, 3'b100);
      chk("drop_no_enable", det_enable, 0);
      finish_frame(16'd0, 2, 1'b0, 1'b0);

      // Fill the FIFO, overflow on the 9th digit, then push+pop at full.
      do_reset();
      for (int d = 1; d <= 9; d++) begin
         frame(16'(d));
         frame(16'(d));
         if (d < 9) frame(16'd0);
      end
      chk("ovf_status", status, 3'b010);
      chk("ovf_count", fifo_count, 8);
      clr_status = 1'b1;
      tick();
      clr_status = 1'b0;
      frame(16'd0);
      frame(16'd3);
      feed_frame(FRAME_LEN, 0);
      finish_frame(16'd3, 4, 1'b1, 1'b0);
      chk("full_pushpop_count", fifo_count, 8);
      chk("full_pushpop_status", status, 3'b000);
      chk("full_pushpop_head", digit, 2);

      // Reset at sample 100 discards the partial frame; next frame needs all 205.
      feed_frame(100, 0);
      reset_n = 1'b0;
      #1;
      chk("midrst_det_enable", det_enable, 0);
      chk("midrst_det_data", det_data, 0);
      chk("midrst_digit_valid", digit_valid, 0);
      chk("midrst_fifo_count", fifo_count, 0);
      chk("midrst_status", status, 0);
      tick();
      reset_n = 1'b1;
      tick();
      feed_frame(FRAME_LEN - 1, 0);
      feed_frame(1, 0);
      chk("midrst_last_sample_fwd", det_enable, 1);
      chk("midrst_no_drop", status, 0);
      finish_frame(16'd7, 5, 1'b0, 1'b0);

      // Randomized frames with gaps, stray samples, noise strobes and pops.
      do_reset();
      rand_pop   = 1'b1;
      rand_noise = 1'b1;
      for (int f = 0; f < 40; f++) begin
         logic [15:0] tone;
         int unsigned r;
         r = $urandom_range(9);
         if (r < 3)      tone = 16'd0;
         else if (r < 6) tone = 16'd5;
         else if (r < 8) tone = 16'd9;
         else            tone = 16'($urandom_range(1, 16));
         feed_frame(FRAME_LEN, 25);
         if ($urandom_range(19) == 0) repeat (TIMEOUT + 3) tick();
         else finish_frame(tone, $urandom_range(0, 80), 1'($urandom_range(1)), 1'b1);
      end
      repeat (5) tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
